// File: rtl/wm_pkg.sv
// Shared types, defaults and sizing helpers for the watermark block-blend engine.
package wm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam int unsigned DATA_DEPTH_DEF = 8;
  localparam int unsigned COEF_FRAC_DEF  = 7;

  // Largest representable pixel value for a given bit depth.
  function automatic int unsigned pix_max(input int unsigned depth);
    return (32'd1 << depth) - 32'd1;
  endfunction

  // Address width needed to index one max-size block of pairs.
  function automatic int unsigned block_idx_w(input int unsigned max_block);
    return (max_block < 2) ? 1 : $clog2(max_block * max_block);
  endfunction

endpackage

// File: rtl/wm_block_buf.sv
// Block pair buffer: simple dual-port RAM, synchronous write, registered read.
module wm_block_buf #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Aw    = 6,
  parameter int unsigned Dw    = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [Aw-1:0] wr_addr,
  input  logic [Dw-1:0] wr_data,
  input  logic          rd_en,
  input  logic [Aw-1:0] rd_addr,
  output logic [Dw-1:0] rd_data
);

  logic [Dw-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/wm_block_blend.sv
// Per-block edge/flat classification and alpha*Ip + beta*Iw blending.
// Optional edge-block counter port enabled by defining WM_BLEND_STATS_EN.
module wm_block_blend
  import wm_pkg::*;
#(
  parameter int unsigned Data_Depth     = DATA_DEPTH_DEF,
  parameter int unsigned Max_Block      = 8,
  parameter int unsigned Coef_Frac      = COEF_FRAC_DEF,
  parameter int unsigned Max_Image_Size = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                cfg_m,
  input  logic [Max_Image_Size-1:0] cfg_nblocks,
  input  logic [Data_Depth-1:0]     cfg_bthr,
  input  logic [Data_Depth-1:0]     cfg_amin,
  input  logic [Data_Depth-1:0]     cfg_amax,
  input  logic [Data_Depth-1:0]     cfg_bmin,
  input  logic [Data_Depth-1:0]     cfg_bmax,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [Data_Depth-1:0]     in_primary,
  input  logic [Data_Depth-1:0]     in_wm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Data_Depth-1:0]     out_pixel,
  output logic                      busy,
`ifdef WM_BLEND_STATS_EN
  output logic [Max_Image_Size-1:0] edge_count,
  output logic                      image_done
`else
  output logic                      image_done
`endif
);

  localparam int unsigned Aw    = block_idx_w(Max_Block);
  localparam int unsigned Cw    = Aw + 1;
  localparam int unsigned Depth = Max_Block * Max_Block;
  localparam int unsigned Pw    = 2 * Data_Depth;
  localparam int unsigned Sw    = Pw + 1;
  localparam logic [3:0]  MaxM  = 4'(Max_Block);
  localparam logic [Sw-1:0] Sat = Sw'(pix_max(Data_Depth));

  state_t state, state_nx;

  logic [Cw-1:0]             n_r, in_cnt, rd_cnt, out_cnt;
  logic [Max_Image_Size-1:0] nblocks_r, block_cnt;
  logic [Data_Depth-1:0]     bthr_r, amin_r, amax_r, bmin_r, bmax_r;
  logic [Data_Depth-1:0]     min_r, max_r, alpha, beta;
  logic [3:0]                m_c;
  logic                      start_ok, acc_in, acc_out, adv, issue;
  logic                      blk_end, img_end, edge_c;
  logic                      v_rd, v_s1;
  logic [Pw-1:0]             rd_data, prod_a, prod_b;
  logic [Sw-1:0]             sum_c, shift_c;

  assign acc_in  = in_valid & in_ready;
  assign acc_out = out_valid & out_ready;
  assign adv     = ~out_valid | out_ready;
  assign edge_c  = (max_r - min_r) > bthr_r;
  assign m_c     = (cfg_m == 4'd0) ? 4'd1 : ((cfg_m > MaxM) ? MaxM : cfg_m);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start && cfg_nblocks != '0) state_nx = ST_FILL;
      ST_FILL:   if (acc_in && in_cnt == n_r - Cw'(1)) state_nx = ST_DECIDE;
      ST_DECIDE: state_nx = ST_DRAIN;
      ST_DRAIN:  if (blk_end) state_nx = img_end ? ST_IDLE : ST_FILL;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    start_ok = 1'b0;
    issue    = 1'b0;
    blk_end  = 1'b0;
    img_end  = 1'b0;
    case (state)
      ST_IDLE:   start_ok = start;
      ST_DECIDE: issue = adv && (rd_cnt < n_r);
      ST_DRAIN: begin
        issue   = adv && (rd_cnt < n_r);
        blk_end = acc_out && (out_cnt == n_r - Cw'(1));
        img_end = blk_end && ((block_cnt + Max_Image_Size'(1)) == nblocks_r);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      in_ready <= (state_nx == ST_FILL);
      busy     <= (state_nx != ST_IDLE);
    end
  end

  // Image configuration, block counters and range tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r <= '0; nblocks_r <= '0; block_cnt <= '0;
      bthr_r <= '0; amin_r <= '0; amax_r <= '0; bmin_r <= '0; bmax_r <= '0;
      in_cnt <= '0; rd_cnt <= '0; out_cnt <= '0;
      min_r <= '0; max_r <= '0; alpha <= '0; beta <= '0;
      image_done <= 1'b0;
    end else begin
      if (start_ok) begin
        n_r        <= Cw'(m_c) * Cw'(m_c);
        nblocks_r  <= cfg_nblocks;
        bthr_r     <= cfg_bthr;
        amin_r     <= cfg_amin;
        amax_r     <= cfg_amax;
        bmin_r     <= cfg_bmin;
        bmax_r     <= cfg_bmax;
        block_cnt  <= '0;
        image_done <= (cfg_nblocks == '0);
      end else if (img_end) begin
        image_done <= 1'b1;
      end
      if (acc_in) begin
        in_cnt <= in_cnt + Cw'(1);
        if (in_cnt == '0 || in_primary < min_r) min_r <= in_primary;
        if (in_cnt == '0 || in_primary > max_r) max_r <= in_primary;
      end
      if (issue)   rd_cnt  <= rd_cnt + Cw'(1);
      if (acc_out) out_cnt <= out_cnt + Cw'(1);
      if (state == ST_DECIDE) begin
        alpha <= edge_c ? amax_r : amin_r;
        beta  <= edge_c ? bmin_r : bmax_r;
      end
      if (blk_end) begin
        in_cnt    <= '0;
        rd_cnt    <= '0;
        out_cnt   <= '0;
        block_cnt <= block_cnt + Max_Image_Size'(1);
      end
    end
  end

`ifdef WM_BLEND_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              edge_count <= '0;
    else if (start_ok)                    edge_count <= '0;
    else if (state == ST_DECIDE && edge_c) edge_count <= edge_count + Max_Image_Size'(1);
  end
`endif

  wm_block_buf #(
    .Depth (Depth),
    .Aw    (Aw),
    .Dw    (Pw)
  ) u_buf (
    .clk     (clk),
    .wr_en   (acc_in),
    .wr_addr (in_cnt[Aw-1:0]),
    .wr_data ({in_primary, in_wm}),
    .rd_en   (issue),
    .rd_addr (rd_cnt[Aw-1:0]),
    .rd_data (rd_data)
  );

  assign sum_c   = Sw'(prod_a) + Sw'(prod_b);
  assign shift_c = sum_c >> Coef_Frac;

  // Read -> multiply -> add/shift/saturate; whole pipe stalls on a held output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_rd      <= 1'b0;
      v_s1      <= 1'b0;
      out_valid <= 1'b0;
      prod_a    <= '0;
      prod_b    <= '0;
      out_pixel <= '0;
    end else if (adv) begin
      v_rd      <= issue;
      v_s1      <= v_rd;
      out_valid <= v_s1;
      if (v_rd) begin
        prod_a <= alpha * rd_data[Pw-1:Data_Depth];
        prod_b <= beta * rd_data[Data_Depth-1:0];
      end
      if (v_s1) out_pixel <= (shift_c > Sat) ? Data_Depth'(Sat) : Data_Depth'(shift_c);
    end
  end

endmodule

// File: tb/tb_wm_block_blend.sv
// Self-checking bench for wm_block_blend: table vectors plus stall/reset/boundary sequences.
module tb_wm_block_blend;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] cfg_m;
  logic [9:0] cfg_nblocks;
  logic [7:0] cfg_bthr, cfg_amin, cfg_amax, cfg_bmin, cfg_bmax;
  logic       in_valid, in_ready;
  logic [7:0] in_primary, in_wm;
  logic       out_valid, out_ready;
  logic [7:0] out_pixel;
  logic       busy, image_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] ip_a [64];
  logic [7:0] iw_a [64];
  logic [7:0] exp_a [64];

  typedef struct packed {
    logic [7:0]  amax;
    logic [7:0]  bmin;
    logic [31:0] ip;
    logic [31:0] iw;
    logic [31:0] expv;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  wm_block_blend dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_m       (cfg_m),
    .cfg_nblocks (cfg_nblocks),
    .cfg_bthr    (cfg_bthr),
    .cfg_amin    (cfg_amin),
    .cfg_amax    (cfg_amax),
    .cfg_bmin    (cfg_bmin),
    .cfg_bmax    (cfg_bmax),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_primary  (in_primary),
    .in_wm       (in_wm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .busy        (busy),
    .image_done  (image_done)
  );

  function automatic logic [31:0] q4(input int a, input int b, input int c, input int d);
    return {8'(a), 8'(b), 8'(c), 8'(d)};
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] v, input int k);
    return 8'(v >> (8 * (3 - k)));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [7:0] model_px(input int ip, input int iw, input bit edge_f);
    int a, b, s;
    a = edge_f ? int'(cfg_amax) : int'(cfg_amin);
    b = edge_f ? int'(cfg_bmin) : int'(cfg_bmax);
    s = (a * ip + b * iw) >> 7;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  task automatic compute_exp(input int m, input int nb);
    int n;
    n = m * m;
    for (int b = 0; b < nb; b++) begin
      int mn, mx;
      bit e;
      mn = 255; mx = 0;
      for (int k = 0; k < n; k++) begin
        if (int'(ip_a[b*n+k]) < mn) mn = int'(ip_a[b*n+k]);
        if (int'(ip_a[b*n+k]) > mx) mx = int'(ip_a[b*n+k]);
      end
      e = (mx - mn) > int'(cfg_bthr);
      for (int k = 0; k < n; k++)
        exp_a[b*n+k] = model_px(int'(ip_a[b*n+k]), int'(iw_a[b*n+k]), e);
    end
  endtask

  task automatic do_start(input logic [3:0] m, input logic [9:0] nb);
    cfg_m = m; cfg_nblocks = nb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed_pair(input logic [7:0] ip, input logic [7:0] iw);
    int t;
    t = 0;
    in_valid = 1'b1; in_primary = ip; in_wm = iw;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL feed_timeout: got in_ready=0, expected 1 within 200 cycles");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic feed_block(input int b, input int m);
    for (int k = 0; k < m * m; k++) feed_pair(ip_a[b*m*m+k], iw_a[b*m*m+k]);
  endtask

  task automatic collect_block(input int b, input int m, input bit rnd, input string tag);
    int n, got, t;
    bit held;
    logic [7:0] hold;
    n = m * m; got = 0; t = 0; hold = '0;
    while (got < n && t < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk(tag, 32'(out_pixel), 32'(exp_a[b*n+got]));
          got++;
        end else begin
          held = 1'b1; hold = out_pixel;
        end
      end
      @(posedge clk); #1; t++;
      if (held) chk("stall_hold", 32'({out_valid, out_pixel}), 32'({1'b1, hold}));
    end
    out_ready = 1'b1;
    if (got < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d outputs, expected %0d", tag, got, n);
    end
  endtask

  task automatic run_blocks(input int m, input int nb, input bit rnd, input string tag);
    for (int b = 0; b < nb; b++) begin
      feed_block(b, m);
      collect_block(b, m, rnd, tag);
    end
  endtask

  task automatic load_stall_data();
    for (int k = 0; k < 4; k++) begin
      ip_a[k] = 8'd100; iw_a[k] = 8'd200;
      ip_a[4+k] = (k < 2) ? 8'd10 : 8'd200; iw_a[4+k] = 8'd200;
    end
    ip_a[8] = 8'd50; ip_a[9] = 8'd71; ip_a[10] = 8'd60; ip_a[11] = 8'd55;
    iw_a[8] = 8'd30; iw_a[9] = 8'd90; iw_a[10] = 8'd255; iw_a[11] = 8'd0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_m = 4'd2; cfg_nblocks = 10'd1;
    cfg_bthr = 8'd20; cfg_amin = 8'h40; cfg_amax = 8'h70; cfg_bmin = 8'h10; cfg_bmax = 8'h30;
    in_valid = 1'b0; in_primary = '0; in_wm = '0; out_ready = 1'b1;

    vecs[0] = '{amax: 8'h70, bmin: 8'h10, ip: q4(100, 100, 100, 100), iw: q4(200, 200, 200, 200), expv: q4(125, 125, 125, 125)};
    vecs[1] = '{amax: 8'h70, bmin: 8'h10, ip: q4(10, 10, 200, 200),   iw: q4(200, 200, 200, 200), expv: q4(33, 33, 200, 200)};
    vecs[2] = '{amax: 8'h70, bmin: 8'h10, ip: q4(50, 70, 50, 70),     iw: q4(0, 0, 0, 0),         expv: q4(25, 35, 25, 35)};
    vecs[3] = '{amax: 8'hFF, bmin: 8'hFF, ip: q4(0, 255, 255, 255),   iw: q4(255, 255, 255, 255), expv: q4(255, 255, 255, 255)};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_image_done", 32'(image_done), 32'd0);
    chk("rst_out_pixel", 32'(out_pixel), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed single-block images
    foreach (vecs[i]) begin
      cfg_amax = vecs[i].amax; cfg_bmin = vecs[i].bmin;
      for (int k = 0; k < 4; k++) begin
        ip_a[k] = lane(vecs[i].ip, k); iw_a[k] = lane(vecs[i].iw, k); exp_a[k] = lane(vecs[i].expv, k);
      end
      do_start(4'd2, 10'd1);
      chk("vec_busy", 32'(busy), 32'd1);
      chk("vec_done_cleared", 32'(image_done), 32'd0);
      run_blocks(2, 1, 1'b0, "vec_pixel");
      chk("vec_image_done", 32'(image_done), 32'd1);
      chk("vec_idle", 32'(busy), 32'd0);
    end
    cfg_amax = 8'h70; cfg_bmin = 8'h10;

    // Output latency after the last pair of a block
    for (int k = 0; k < 4; k++) begin
      ip_a[k] = 8'd100; iw_a[k] = 8'd200; exp_a[k] = 8'd125;
    end
    do_start(4'd2, 10'd1);
    feed_block(0, 2);
    chk("lat_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_c1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_c2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_c3", 32'({out_valid, out_pixel}), 32'({1'b1, 8'd125}));
    collect_block(0, 2, 1'b0, "lat_pixel");
    chk("lat_image_done", 32'(image_done), 32'd1);

    // Three blocks without and with random back-pressure, plus an ignored start
    load_stall_data();
    compute_exp(2, 3);
    do_start(4'd2, 10'd3);
    run_blocks(2, 3, 1'b0, "nostall_pixel");
    chk("nostall_done", 32'(image_done), 32'd1);
    do_start(4'd2, 10'd3);
    cfg_m = 4'd1; cfg_nblocks = 10'd1; cfg_amax = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_ignored", 32'({busy, in_ready}), 32'b11);
    run_blocks(2, 3, 1'b1, "stall_pixel");
    chk("stall_done", 32'(image_done), 32'd1);
    cfg_amax = 8'h70;

    // Reset in the middle of block 2
    load_stall_data();
    compute_exp(2, 2);
    do_start(4'd2, 10'd2);
    feed_block(0, 2);
    collect_block(0, 2, 1'b0, "pre_rst_pixel");
    feed_pair(ip_a[4], iw_a[4]);
    feed_pair(ip_a[5], iw_a[5]);
    rst = 1'b1;
    #2;
    chk("mid_rst_out_pixel", 32'(out_pixel), 32'd0);
    chk("mid_rst_flags", 32'({out_valid, in_ready, busy, image_done}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_start(4'd2, 10'd0);
    chk("nblocks0_done", 32'({image_done, busy}), 32'b10);
    do_start(4'd2, 10'd2);
    chk("restart_done_cleared", 32'(image_done), 32'd0);
    run_blocks(2, 2, 1'b0, "restart_pixel");
    chk("restart_done", 32'(image_done), 32'd1);

    // Start and reset together: reset wins
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_idle", 32'({busy, in_ready}), 32'd0);

    // cfg_m = 0 behaves as M=1 (always flat); Ip=200, Iw=0 -> 64*200>>7 = 100
    cfg_bthr = 8'd0;
    ip_a[0] = 8'd200; iw_a[0] = 8'd0; exp_a[0] = 8'd100;
    do_start(4'd0, 10'd1);
    run_blocks(1, 1, 1'b0, "m1_pixel");
    chk("m1_done", 32'(image_done), 32'd1);

    // cfg_m above the maximum clamps to 8x8
    cfg_bthr = 8'd20;
    for (int k = 0; k < 64; k++) begin
      ip_a[k] = 8'(k * 4); iw_a[k] = 8'(k);
    end
    compute_exp(8, 1);
    do_start(4'd12, 10'd1);
    run_blocks(8, 1, 1'b1, "m8_pixel");
    chk("m8_done", 32'({image_done, busy, in_ready}), 32'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
